// File: rtl/branch_sequencer.sv
// branch_sequencer: T3..T6 control sequencing for conditional branches (brzr/brnz/brpl/brmi).
// Define BRANCH_SEQ_STATS_EN to add saturating taken/not-taken counters.
module branch_sequencer #(
    parameter int                  OPCODE_W  = 5,
    parameter logic [OPCODE_W-1:0] BR_OPCODE = 5'b10010,
    parameter int                  C2_LSB    = 19
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        con_out,
    output logic        busy,
    output logic        gra,
    output logic        r_out,
    output logic        con_in,
    output logic        pc_out,
    output logic        y_in,
    output logic        c_out,
    output logic        alu_add,
    output logic        z_in,
    output logic        zlow_out,
    output logic        pc_in,
    output logic        done,
    output logic        taken,
    output logic        err
`ifdef BRANCH_SEQ_STATS_EN
    ,
    output logic [15:0] taken_cnt,
    output logic [15:0] not_taken_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, T3, T4, T5, T6} state_t;
    state_t state, state_nxt;
    logic   is_br;
    // The condition field reaches the CON FF through IR; the sequencer only strobes it.
    logic   unused_ir;
    assign unused_ir = ^{ir, ir[C2_LSB+1:C2_LSB]};
    assign is_br     = ir[31 -: OPCODE_W] == BR_OPCODE;
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            taken <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= state == IDLE && start && !is_br;
            if (state == T6) taken <= con_out;
        end
    end
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start && is_br ? T3 : IDLE;
            T3:      state_nxt = T4;
            T4:      state_nxt = T5;
            T5:      state_nxt = T6;
            default: state_nxt = IDLE;
        endcase
    end
    assign busy     = state != IDLE;
    assign gra      = state == T3;
    assign r_out    = state == T3;
    assign con_in   = state == T3;
    assign pc_out   = state == T4;
    assign y_in     = state == T4;
    assign c_out    = state == T5;
    assign alu_add  = state == T5;
    assign z_in     = state == T5;
    assign zlow_out = state == T6;
    assign done     = state == T6;
    assign pc_in    = state == T6 && con_out;
`ifdef BRANCH_SEQ_STATS_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (state == T6) begin
            if (con_out && taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
            if (!con_out && not_taken_cnt != 16'hFFFF) not_taken_cnt <= not_taken_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed stimulus with a cycle-level branch model checked every cycle.
module tb_branch_sequencer;
    localparam logic [4:0] BR  = 5'b10010;
    localparam logic [4:0] BAD = 5'b00011;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ir = '0;
    logic        con_out = 1'b0;
    logic busy, gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, done, taken, err;
`ifdef BRANCH_SEQ_STATS_EN
    logic [15:0] taken_cnt, not_taken_cnt;
`endif
    int checks = 0;
    int failures = 0;
    int n_done = 0;

    branch_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .con_out(con_out),
        .busy(busy), .gra(gra), .r_out(r_out), .con_in(con_in), .pc_out(pc_out),
        .y_in(y_in), .c_out(c_out), .alu_add(alu_add), .z_in(z_in), .zlow_out(zlow_out),
        .pc_in(pc_in), .done(done), .taken(taken), .err(err)
`ifdef BRANCH_SEQ_STATS_EN
        , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: m_step counts cycles into an accepted branch (0 = idle, 1..4 = T3..T6).
    int          m_step = 0;
    logic        m_err = 1'b0;
    logic        m_taken = 1'b0;
    logic [15:0] m_tc = '0;
    logic [15:0] m_ntc = '0;
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_step = 0; m_err = 1'b0; m_taken = 1'b0; m_tc = '0; m_ntc = '0;
        end else begin
            m_err = m_step == 0 && start && ir[31:27] != BR;
            if (m_step == 4) begin
                m_taken = con_out;
                if (con_out) m_tc = m_tc == 16'hFFFF ? m_tc : m_tc + 16'd1;
                else m_ntc = m_ntc == 16'hFFFF ? m_ntc : m_ntc + 16'd1;
            end
            if (m_step == 0) m_step = start && ir[31:27] == BR ? 1 : 0;
            else m_step = m_step == 4 ? 0 : m_step + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [13:0] e;
        e = {m_step != 0, m_step == 1, m_step == 1, m_step == 1, m_step == 2, m_step == 2,
             m_step == 3, m_step == 3, m_step == 3, m_step == 4, m_step == 4 && con_out,
             m_step == 4, m_taken, m_err};
        chk("cycle_outputs", {18'd0, busy, gra, r_out, con_in, pc_out, y_in, c_out, alu_add,
            z_in, zlow_out, pc_in, done, taken, err}, {18'd0, e});
`ifdef BRANCH_SEQ_STATS_EN
        chk("cycle_counters", {taken_cnt, not_taken_cnt}, {m_tc, m_ntc});
`endif
        if (done === 1'b1) n_done++;
    end

    // Issue one branch; poke re-asserts start in T4 and T6 (must be ignored).
    task automatic do_branch(input logic c, input logic poke);
        @(posedge clk); #1; ir = {BR, 8'h00, 2'b01, 17'h1234}; start = 1'b1; con_out = c;
        @(posedge clk); #1; start = 1'b0;
        #3 chk("t3", {busy, gra, r_out, con_in, pc_out, y_in}, 6'b111100);
        @(posedge clk); #1; start = poke;
        #3 chk("t4", {busy, pc_out, y_in, gra, c_out}, 5'b11100);
        @(posedge clk); #1; start = 1'b0;
        #3 chk("t5", {c_out, alu_add, z_in, pc_out, zlow_out}, 5'b11100);
        @(posedge clk); #1; start = poke;
        #3 chk("t6", {zlow_out, done, pc_in, c_out}, {1'b1, 1'b1, c, 1'b0});
        @(posedge clk); #1; start = 1'b0;
        #3 chk("after_t6", {busy, done, taken, err}, {1'b0, 1'b0, c, 1'b0});
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        #3 chk("reset_state", {busy, gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
            zlow_out, pc_in, done, taken, err}, 14'd0);
        do_branch(1'b1, 1'b0);
        do_branch(1'b0, 1'b0);
        // Illegal opcode
        @(posedge clk); #1; ir = {BAD, 27'h0}; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        #3 chk("err_pulse", {err, busy, gra, pc_out}, 4'b1000);
        @(posedge clk); #4 chk("err_clear", {err, busy}, 2'b00);
        // start while busy
        d0 = n_done;
        do_branch(1'b1, 1'b1);
        @(posedge clk); #4 chk("busy_one_done", n_done - d0, 1);
        chk("still_idle", {busy, err}, 2'b00);
        // Async reset in the middle of T5
        @(posedge clk); #1; ir = {BR, 27'h0}; start = 1'b1; con_out = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); #4;
        chk("in_t5", {c_out, busy}, 2'b11);
        clr = 1'b1;
        #1 chk("async_clr", {busy, gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
            zlow_out, pc_in, done, taken, err}, 14'd0);
        @(posedge clk); #1; clr = 1'b0;
        #3 chk("post_clr", {busy, taken}, 2'b00);
        @(posedge clk); #4 chk("no_pc_load", {busy, pc_in, done}, 3'b000);
`ifdef BRANCH_SEQ_STATS_EN
        do_branch(1'b1, 1'b0);
        do_branch(1'b0, 1'b0);
        do_branch(1'b1, 1'b0);
        do_branch(1'b0, 1'b0);
        do_branch(1'b1, 1'b0);
        chk("cnt_taken", taken_cnt, 3);
        chk("cnt_not_taken", not_taken_cnt, 2);
        @(posedge clk); #1;
        force dut.taken_cnt = 16'hFFFF;
        #1 release dut.taken_cnt;
        m_tc = 16'hFFFF;
        do_branch(1'b1, 1'b0);
        chk("cnt_saturate", taken_cnt, 16'hFFFF);
        chk("cnt_nt_hold", not_taken_cnt, 2);
`endif
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Control FSM that sequences conditional-branch instructions (brzr/brnz/brpl/brmi) through the datapath: register read into the bus, CON flip-flop strobe, PC+offset computation, and conditional PC load.
- Sits between instruction decode and the datapath control lines. Drives the CON FF load strobe (con_in) and consumes its registered result (con_out).
- Handles only steps T3..T6 of a branch; fetch (T0..T2) belongs to the main control unit.

Parameters:
- OPCODE_W, 5, width of the IR opcode field at IR[31:32-OPCODE_W].
- BR_OPCODE, 5'b10010, opcode value identifying a conditional branch.
- C2_LSB, 19, LSB position of the 2-bit condition field IR[C2_LSB+1:C2_LSB] (00 zero, 01 nonzero, 10 positive, 11 negative).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request from decode: IR holds a new instruction to execute.
- ir  in  32  current instruction register contents.
- con_out  in  1  registered branch condition from the CON FF.
- busy  out  1  high in any state other than IDLE.
- gra  out  1  select Ra field for register-file addressing.
- r_out  out  1  drive the selected register onto the bus.
- con_in  out  1  CON FF load strobe.
- pc_out  out  1  drive PC onto the bus.
- y_in  out  1  load Y register.
- c_out  out  1  drive sign-extended C constant onto the bus.
- alu_add  out  1  ALU operation = ADD.
- z_in  out  1  load Z register.
- zlow_out  out  1  drive Zlow onto the bus.
- pc_in  out  1  load PC from the bus.
- done  out  1  one-cycle pulse on the final branch step.
- taken  out  1  registered result of the last completed branch.
- err  out  1  one-cycle pulse when start arrives with a non-branch opcode.

Behaviour:
- States: IDLE, T3, T4, T5, T6. One-hot or binary encoding is acceptable.
- Reset (clr=1, asynchronous):
  - state goes to IDLE.
  - All outputs are 0, including taken and err.
  - Reset mid-operation aborts immediately. Control lines drop without waiting for a clock edge. No partial PC load.
- IDLE: all control outputs 0.
  - start=1 and opcode==BR_OPCODE: next state T3.
  - start=1 and opcode!=BR_OPCODE: stay in IDLE and pulse err for the next cycle (registered).
- T3: gra=1, r_out=1, con_in=1. The CON FF captures the condition on the edge ending T3. Next state T4.
- T4: pc_out=1, y_in=1. con_out is valid from this cycle. Next state T5.
- T5: c_out=1, alu_add=1, z_in=1. Next state T6.
- T6: zlow_out=1, done=1, pc_in=con_out (combinational gate on the current con_out).
  - On the edge ending T6, taken <= con_out.
  - Next state is always IDLE.
- All control outputs except pc_in are pure Moore decodes of the state.
- Latency: start accepted at edge N; T3..T6 occupy cycles N+1..N+4; done is high in cycle N+4; busy is back to 0 at N+5.
- start while busy=1 is ignored: no queueing, no err.
- Back-to-back operation: start asserted in the T6 cycle is ignored. start is accepted only in IDLE.
- Condition field: the sequencer does not decode it. It is forwarded implicitly via IR to the CON FF, and the sequencer only strobes con_in.
- taken holds its value until the next T6 or reset.

Optional Feature:
- Macro: BRANCH_SEQ_STATS_EN.
- When defined:
  - Adds outputs taken_cnt[15:0] and not_taken_cnt[15:0], reset to 0 by clr.
  - On the edge ending T6, the counter matching con_out increments by 1.
  - Both counters saturate at 16'hFFFF (no wrap).
- When undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset behaviour: assert clr mid-T5 -> all outputs 0 asynchronously, before the next edge; state IDLE; after release, busy=0, taken=0.
- Branch taken: ir opcode 5'b10010, start pulse, con_out forced 1 from T4 -> sequence gra/r_out/con_in, pc_out/y_in, c_out/alu_add/z_in, zlow_out/pc_in=1/done on 4 consecutive cycles; taken=1 afterwards.
- Branch not taken: same stimulus, con_out=0 -> T6 shows zlow_out=1, done=1, pc_in=0; taken=0.
- Illegal opcode: start with opcode 5'b00011 -> busy stays 0, err=1 for exactly one cycle, no control line asserted.
- start while busy: pulse start in T4 and again in T6 -> ignored; exactly one done pulse; busy=0 one cycle after T6.
- With BRANCH_SEQ_STATS_EN defined: 3 taken plus 2 not-taken branches -> taken_cnt=3, not_taken_cnt=2. Preload 16'hFFFF via force and run a taken branch -> taken_cnt stays 16'hFFFF.
